wb_writeback_unit: RTL

Writeback end of the register-file write port: drives `rd`/`write_data`/write-enable into the 32x32 register file from a one-entry MEM/WB pipeline register, with load alignment/extension, result selection and x0 suppression. It also keeps a per-register pending-write scoreboard so decode can stall on operands not yet written back. It sits between the MEM stage and the register file.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_load_align.sv | 30 +++
 rtl/wb_writeback_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings and sizes for the writeback unit: result selects, load sizes,
// register index width and scoreboard counter width.
package wb_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int SB_CNT_W  = 2;

  localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_LINK = 2'b10,
    SEL_NONE = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } ld_size_e;

endpackage

// File: rtl/wb_load_align.sv
// Load lane select and sign/zero extension of a raw memory word.
// Size 2'b11 is treated as a full word.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic [N-1:0] data,
  input  logic [1:0]   size,
  input  logic         is_unsigned,
  input  logic [1:0]   off,
  output logic [N-1:0] result
);

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;

  always_comb begin
    byte_lane = data[{off, 3'b000} +: 8];
    // Halfword lane ignores off[0]; misaligned halves are not split.
    half_lane = data[{off[1], 4'b0000} +: 16];
    result    = data;
    case (size)
      SIZE_B:  result = {{(N-8){byte_lane[7] & ~is_unsigned}}, byte_lane};
      SIZE_H:  result = {{(N-16){half_lane[15] & ~is_unsigned}}, half_lane};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// MEM/WB register, register-file write port and per-register pending-write scoreboard.
// Optional macro WB_BYPASS_EN enables forwarding outputs and retiring-write busy suppression.
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int N     = XLEN,
  parameter int DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_we,
  input  logic [1:0]           in_sel,
  input  logic [N-1:0]         in_alu_result,
  input  logic [N-1:0]         in_load_data,
  input  logic [1:0]           in_load_size,
  input  logic                 in_load_unsigned,
  input  logic [1:0]           in_byte_off,
  input  logic [N-1:0]         in_pc_plus4,
  input  logic                 wb_hold,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [N-1:0]         rf_wdata,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 issue_stall,
  output logic [31:0]          retire_count,
  output logic                 rs1_fwd,
  output logic                 rs2_fwd,
  output logic [N-1:0]         fwd_data
);

  function automatic logic [SB_CNT_W-1:0] sb_next(input logic [SB_CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [SB_CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec && cnt != SB_CNT_MAX) res = cnt + 1'b1;
    if (dec && !inc && cnt != '0)         res = cnt - 1'b1;
    return res;
  endfunction

  logic                 wb_valid_q;
  logic                 wb_we_eff_q;
  logic [REG_IDX_W-1:0] wb_rd_q;
  logic [N-1:0]         wb_data_q;
  logic [31:0]          retire_cnt_q;
  logic [SB_CNT_W-1:0]  sb_cnt [DEPTH];

  logic [N-1:0] load_val;
  logic [N-1:0] result_d;
  logic         we_eff_d;
  logic         capture;
  logic         retire;
  logic         sb_inc;
  logic         sb_dec;
  logic         rs1_pend;
  logic         rs2_pend;

  wb_load_align #(.N(N)) u_load_align (
    .data        (in_load_data),
    .size        (in_load_size),
    .is_unsigned (in_load_unsigned),
    .off         (in_byte_off),
    .result      (load_val)
  );

  always_comb begin
    case (in_sel)
      SEL_LOAD: result_d = load_val;
      SEL_LINK: result_d = in_pc_plus4;
      default:  result_d = in_alu_result;
    endcase
  end

  assign we_eff_d = in_we & (in_sel != SEL_NONE) & (in_rd != '0);
  assign in_ready = ~wb_valid_q | ~wb_hold;
  assign capture  = in_valid & in_ready;
  assign retire   = wb_valid_q & ~wb_hold;
  assign sb_inc   = issue_valid & issue_we & (issue_rd != '0);
  assign sb_dec   = retire & wb_we_eff_q;

  // MEM -> WB boundary: result is fully formed here so the write port is register-driven
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_we_eff_q  <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      wb_valid_q <= capture | (wb_valid_q & ~retire);
      if (capture) begin
        wb_we_eff_q <= we_eff_d;
        wb_rd_q     <= in_rd;
        wb_data_q   <= result_d;
      end
      if (retire) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_cnt[i] <= '0;
    end else begin
      sb_cnt[0] <= '0;
      for (int i = 1; i < DEPTH; i++)
        sb_cnt[i] <= sb_next(sb_cnt[i],
                             sb_inc && (issue_rd == REG_IDX_W'(i)),
                             sb_dec && (wb_rd_q == REG_IDX_W'(i)));
    end
  end

  assign rf_we        = retire & wb_we_eff_q;
  assign rf_rd        = wb_rd_q;
  assign rf_wdata     = wb_data_q;
  assign retire_count = retire_cnt_q;

  assign rs1_pend = sb_cnt[rs1] != '0;
  assign rs2_pend = sb_cnt[rs2] != '0;

`ifdef WB_BYPASS_EN
  assign rs1_fwd  = rf_we & (rf_rd == rs1);
  assign rs2_fwd  = rf_we & (rf_rd == rs2);
  assign fwd_data = rf_wdata;
  // Last outstanding write is on the port right now, so the forwarded value covers it
  assign rs1_busy = rs1_pend & ~((sb_cnt[rs1] == SB_CNT_W'(1)) & rs1_fwd);
  assign rs2_busy = rs2_pend & ~((sb_cnt[rs2] == SB_CNT_W'(1)) & rs2_fwd);
`else
  assign rs1_fwd  = 1'b0;
  assign rs2_fwd  = 1'b0;
  assign fwd_data = '0;
  assign rs1_busy = rs1_pend;
  assign rs2_busy = rs2_pend;
`endif

  assign issue_stall = rs1_busy | rs2_busy | (sb_cnt[issue_rd] == SB_CNT_MAX);

endmodule
